// File: rtl/act_requant_if.sv
// act_requant_if: lane bus between the matmul/bias output, the requantizer and
// the GELU activation stage. The accumulator lanes and their valids flow in, and
// the requantized fixed-point lanes and their valids flow out.
//   master : the side that produces accumulators and consumes fixed-point lanes
//   slave  : the requantizer itself
interface act_requant_if #(
  parameter int BUS_NUM          = 8,
  parameter int ACC_WIDTH        = 24,
  parameter int FIXED_DATA_WIDTH = 8
);

  logic [BUS_NUM*ACC_WIDTH-1:0]        in_acc_data;
  logic [BUS_NUM-1:0]                  in_acc_vld;
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] out_fixed_data;
  logic [BUS_NUM-1:0]                  out_fixed_vld;

  modport master (
    output in_acc_data,
    output in_acc_vld,
    input  out_fixed_data,
    input  out_fixed_vld
  );

  modport slave (
    input  in_acc_data,
    input  in_acc_vld,
    output out_fixed_data,
    output out_fixed_vld
  );

endinterface

// File: rtl/act_requant.sv
// act_requant: two-stage requantizer feeding the GELU activation stage.
//   stage 1 : prod = acc * scale (full precision), valid and shift captured alongside
//   stage 2 : round half toward +inf, arithmetic shift right, saturate to the
//             signed fixed-point output width, register onto the output bus
// Each lane is independent; there is no backpressure.
// Optional feature: define ACT_REQUANT_SAT_CNT_EN to build the saturation event
// counter; without it sat_cnt is tied to zero and sat_cnt_clr is ignored.
module act_requant #(
  parameter int BUS_NUM          = 8,
  parameter int ACC_WIDTH        = 24,
  parameter int SCALE_WIDTH      = 16,
  parameter int SCALA_POS_WIDTH  = 5,
  parameter int FIXED_DATA_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  act_requant_if.slave                      bus,
  input  logic                              cfg_load,
  input  logic signed [SCALE_WIDTH-1:0]     cfg_scale,
  input  logic [SCALA_POS_WIDTH-1:0]        cfg_shift,
  output logic                              busy,
  output logic [15:0]                       sat_cnt,
  input  logic                              sat_cnt_clr
);

  // Full product width, plus one extra bit so the rounding add cannot wrap.
  localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH;
  localparam int SUM_W  = PROD_W + 1;

  // Clamp bounds expressed at the rounding width: +2^(FDW-1)-1 and its complement.
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-FIXED_DATA_WIDTH+1){1'b0}}, {(FIXED_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  // Saturated output codes at the lane width.
  localparam logic [FIXED_DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(FIXED_DATA_WIDTH-1){1'b1}}};
  localparam logic [FIXED_DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(FIXED_DATA_WIDTH-1){1'b0}}};

  // Live configuration.
  logic signed [SCALE_WIDTH-1:0]     scale_q;
  logic [SCALA_POS_WIDTH-1:0]        shift_q;

  // Stage 1 state.
  logic signed [PROD_W-1:0]          prod_c [BUS_NUM];
  logic signed [PROD_W-1:0]          prod1  [BUS_NUM];
  logic [BUS_NUM-1:0]                vld1;
  logic [SCALA_POS_WIDTH-1:0]        shift1;

  // Stage 2 next values and state.
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] data_d;
  logic [BUS_NUM-1:0]                  lane_sat;
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] data2;
  logic [BUS_NUM-1:0]                  vld2;

  // Rounding constant 2^(shift-1), zero when no shift; shared by all lanes.
  logic signed [SUM_W-1:0]           rnd_w;

  // Config registers: a load takes effect at its own edge, so any vector sampled
  // on that edge still multiplies by the previous scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale_q <= SCALE_WIDTH'(1);
      shift_q <= '0;
    end else if (cfg_load) begin
      scale_q <= cfg_scale;
      shift_q <= cfg_shift;
    end
  end

  // Per-lane full-precision multiply. Size casts of signed operands sign-extend.
  for (genvar g = 0; g < BUS_NUM; g++) begin : g_mul
    logic signed [ACC_WIDTH-1:0] acc_s;
    assign acc_s     = bus.in_acc_data[g*ACC_WIDTH +: ACC_WIDTH];
    assign prod_c[g] = PROD_W'(acc_s) * PROD_W'(scale_q);
  end

  // Stage 1 register: products of valid lanes, their valids, and the shift that
  // belongs to this vector so later config loads cannot touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUS_NUM; i++) begin
        prod1[i] <= '0;
      end
      vld1   <= '0;
      shift1 <= '0;
    end else begin
      for (int i = 0; i < BUS_NUM; i++) begin
        prod1[i] <= bus.in_acc_vld[i] ? prod_c[i] : '0;
      end
      vld1   <= bus.in_acc_vld;
      shift1 <= shift_q;
    end
  end

  // Half-LSB of the shifted result, added before the shift to round half up.
  always_comb begin
    rnd_w = '0;
    if (shift1 != '0) begin
      rnd_w = SUM_W'(1) << (shift1 - SCALA_POS_WIDTH'(1));
    end
  end

  // Per-lane round, arithmetic shift and clamp. Invalid lanes emit zero and
  // never count as saturating.
  for (genvar g = 0; g < BUS_NUM; g++) begin : g_rq
    logic signed [SUM_W-1:0]      sum_w;
    logic signed [SUM_W-1:0]      shr_w;
    logic                         over_hi;
    logic                         over_lo;
    logic [FIXED_DATA_WIDTH-1:0]  clamp_d;

    assign sum_w   = SUM_W'(prod1[g]) + rnd_w;
    assign shr_w   = sum_w >>> shift1;
    assign over_hi = shr_w > SAT_MAX;
    assign over_lo = shr_w < SAT_MIN;
    assign clamp_d = over_hi ? OUT_MAX :
                     over_lo ? OUT_MIN :
                               shr_w[FIXED_DATA_WIDTH-1:0];

    assign lane_sat[g] = vld1[g] & (over_hi | over_lo);
    assign data_d[g*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] = vld1[g] ? clamp_d : '0;
  end

  // Stage 2 register: the requantized lanes as seen by the activation stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data2 <= '0;
      vld2  <= '0;
    end else begin
      data2 <= data_d;
      vld2  <= vld1;
    end
  end

  assign bus.out_fixed_data = data2;
  assign bus.out_fixed_vld  = vld2;

  // Busy while any lane is in flight in either stage.
  assign busy = (|vld1) | (|vld2);

`ifdef ACT_REQUANT_SAT_CNT_EN
  // Saturation counter: one count per cycle with any clamped valid lane,
  // sticky at all-ones, and a clear beats a simultaneous increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      sat_cnt <= '0;
    end else if ((|lane_sat) && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_cnt_clr | (|lane_sat);
  assign sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_act_requant.sv
// tb_act_requant: self-checking bench for act_requant.
// A behavioural model (integer round/shift/clamp plus a two-entry pipe) predicts
// every output; directed table vectors, hand sequences for config timing and
// reset, randomized traffic, and the saturation counter run are compared to it.
module tb_act_requant;

  localparam int BN = 8;
  localparam int AW = 24;
  localparam int SW = 16;
  localparam int PW = 5;
  localparam int FW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 cfg_load = 1'b0;
  logic signed [SW-1:0] cfg_scale = '0;
  logic [PW-1:0]        cfg_shift = '0;
  logic                 busy;
  logic [15:0]          sat_cnt;
  logic                 sat_cnt_clr = 1'b0;

  always #5 clk = ~clk;

  act_requant_if #(.BUS_NUM(BN), .ACC_WIDTH(AW), .FIXED_DATA_WIDTH(FW)) bus ();

  act_requant #(
    .BUS_NUM(BN), .ACC_WIDTH(AW), .SCALE_WIDTH(SW),
    .SCALA_POS_WIDTH(PW), .FIXED_DATA_WIDTH(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cfg_load(cfg_load),
    .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift),
    .busy(busy),
    .sat_cnt(sat_cnt),
    .sat_cnt_clr(sat_cnt_clr)
  );

  // Reference model state.
  longint      m_scale;
  int          m_shift;
  logic [63:0] p1_data, ex_data;
  logic [7:0]  p1_vld, ex_vld;
  bit          p1_sat;
  int          m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [7:0]  vld;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic [95:0] acc;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  // Integer requantization: floor((acc*scale + 2^(shift-1)) / 2^shift), clamped.
  function automatic logic [7:0] refRequant(input longint acc, input longint scale,
                                            input int shift, output bit clamped);
    longint p, d, num, q;
    p = acc * scale;
    if (shift == 0) begin
      q = p;
    end else begin
      d   = longint'(1) << shift;
      num = p + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
    end
    clamped = 1'b0;
    if (q > 127) begin
      q = 127;
      clamped = 1'b1;
    end else if (q < -128) begin
      q = -128;
      clamped = 1'b1;
    end
    return q[7:0];
  endfunction

  task automatic computeVector(input logic [BN*AW-1:0] acc, input logic [7:0] vld,
                               output logic [63:0] data, output bit any_sat);
    bit c;
    longint a;
    data    = '0;
    any_sat = 1'b0;
    for (int i = 0; i < BN; i++) begin
      if (vld[i]) begin
        a = longint'($signed(acc[i*AW +: AW]));
        data[i*FW +: FW] = refRequant(a, m_scale, m_shift, c);
        any_sat = any_sat | c;
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic checkOutput();
    checkVal("out_fixed_data", 64'(bus.out_fixed_data), ex_data);
    checkVal("out_fixed_vld", 64'(bus.out_fixed_vld), 64'(ex_vld));
    checkVal("busy", 64'(busy), 64'((|p1_vld) | (|ex_vld)));
`ifdef ACT_REQUANT_SAT_CNT_EN
    checkVal("sat_cnt", 64'(sat_cnt), 64'(m_cnt));
`else
    checkVal("sat_cnt", 64'(sat_cnt), 64'(0));
`endif
  endtask

  // One clock of stimulus: drive, advance the model across the edge, compare.
  task automatic applyStimulus(input logic [BN*AW-1:0] acc, input logic [7:0] vld,
                               input bit load, input logic [15:0] scale,
                               input logic [4:0] shift, input bit clr);
    logic [63:0] nd;
    bit ns;
    bus.in_acc_data = acc;
    bus.in_acc_vld  = vld;
    cfg_load        = load;
    cfg_scale       = scale;
    cfg_shift       = shift;
    sat_cnt_clr     = clr;
    computeVector(acc, vld, nd, ns);
    @(posedge clk);
    #1;
    if (clr) m_cnt = 0;
    else if (p1_sat && m_cnt < 65535) m_cnt++;
    ex_data = p1_data;
    ex_vld  = p1_vld;
    p1_data = nd;
    p1_vld  = vld;
    p1_sat  = ns;
    if (load) begin
      m_scale = longint'($signed(scale));
      m_shift = int'(shift);
    end
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus('0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic loadCfg(input logic [15:0] scale, input logic [4:0] shift);
    applyStimulus('0, '0, 1'b1, scale, shift, 1'b0);
  endtask

  // Asserts reset away from a clock edge, checks outputs clear at once, releases.
  task automatic resetDut();
    bus.in_acc_data = '0;
    bus.in_acc_vld  = '0;
    cfg_load        = 1'b0;
    sat_cnt_clr     = 1'b0;
    rst = 1'b1;
    #1;
    m_scale = 1;
    m_shift = 0;
    p1_data = '0; p1_vld = '0; p1_sat = 1'b0;
    ex_data = '0; ex_vld = '0;
    m_cnt   = 0;
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput();
  endtask

  function automatic logic [95:0] pack4acc(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [31:0] pack4exp(input int e0, input int e1, input int e2, input int e3);
    return {FW'(e3), FW'(e2), FW'(e1), FW'(e0)};
  endfunction

  function automatic logic [BN*AW-1:0] rep8(input int a);
    return {BN{AW'(a)}};
  endfunction

  initial begin
    logic [BN*AW-1:0] racc;
    logic [7:0]       rv;
    int               a;
    int               s;

    bus.in_acc_data = '0;
    bus.in_acc_vld  = '0;

    // Directed vectors on lanes 0..3 with hand-computed results.
    tbl[0] = '{8'h01, 16'd1, 5'd0, pack4acc(100, 300, -300, 0), pack4exp(100, 0, 0, 0)};
    tbl[1] = '{8'h0F, 16'd1, 5'd0, pack4acc(100, 300, -300, 0), pack4exp(100, 127, -128, 0)};
    tbl[2] = '{8'h0F, 16'd3, 5'd2, pack4acc(10, -10, 2, 0), pack4exp(8, -7, 2, 0)};
    tbl[3] = '{8'h0F, 16'hFFFE, 5'd1, pack4acc(5, -5, 64, -64), pack4exp(-5, 5, -64, 64)};
    tbl[4] = '{8'h0F, 16'd1000, 5'd31, pack4acc(8388607, -8388608, 0, 1), pack4exp(4, -4, 0, 0)};
    tbl[5] = '{8'h0F, 16'h8000, 5'd0, pack4acc(-8388608, 1, 0, -1), pack4exp(127, -128, 0, 127)};
    tbl[6] = '{8'h0F, 16'd16, 5'd5, pack4acc(1, -1, 254, -257), pack4exp(1, 0, 127, -128)};

    #2;
    resetDut();

    for (int k = 0; k < 7; k++) begin
      loadCfg(tbl[k].scale, tbl[k].shift);
      applyStimulus({96'h0, tbl[k].acc}, tbl[k].vld, 1'b0, '0, '0, 1'b0);
      idle();
      checkVal($sformatf("table%0d_data", k), 64'(bus.out_fixed_data[31:0]), 64'(tbl[k].exp));
      checkVal($sformatf("table%0d_vld", k), 64'(bus.out_fixed_vld), 64'(tbl[k].vld));
      idle();
    end

    // Back-to-back vectors with a scale change landing on the second one.
    loadCfg(16'd1, 5'd0);
    applyStimulus(rep8(10), 8'hFF, 1'b0, '0, '0, 1'b0);
    checkVal("b2b_busy_a", 64'(busy), 64'(1));
    applyStimulus(rep8(20), 8'hFF, 1'b1, 16'd2, 5'd0, 1'b0);
    checkVal("b2b_out_a", 64'(bus.out_fixed_data[7:0]), 64'(8'd10));
    applyStimulus(rep8(30), 8'hFF, 1'b0, '0, '0, 1'b0);
    checkVal("b2b_out_b", 64'(bus.out_fixed_data[7:0]), 64'(8'd20));
    idle();
    checkVal("b2b_out_c", 64'(bus.out_fixed_data[7:0]), 64'(8'd60));
    checkVal("b2b_busy_c", 64'(busy), 64'(1));
    idle();
    checkVal("b2b_vld_end", 64'(bus.out_fixed_vld), 64'(0));
    checkVal("b2b_busy_end", 64'(busy), 64'(0));

    // Reset with both stages full, then confirm scale=1 / shift=0 are restored.
    loadCfg(16'd5, 5'd1);
    applyStimulus(rep8(7), 8'hFF, 1'b0, '0, '0, 1'b0);
    applyStimulus(rep8(9), 8'hFF, 1'b0, '0, '0, 1'b0);
    resetDut();
    checkVal("rst_busy", 64'(busy), 64'(0));
    applyStimulus(rep8(77), 8'h01, 1'b0, '0, '0, 1'b0);
    idle();
    checkVal("rst_cfg_data", 64'(bus.out_fixed_data), 64'(8'd77));
    idle();

    // Randomized traffic with occasional config loads and counter clears.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < BN; i++) begin
        if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 4000)) - 2000;
        else a = int'($urandom);
        racc[i*AW +: AW] = AW'(a);
      end
      rv = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0) s = int'($urandom);
        else s = int'($urandom_range(0, 600)) - 300;
        applyStimulus(racc, rv, 1'b1, 16'(s), 5'($urandom_range(0, 12)),
                      $urandom_range(0, 19) == 0);
      end else begin
        applyStimulus(racc, rv, 1'b0, '0, '0, $urandom_range(0, 19) == 0);
      end
    end
    idle();
    idle();

    // Continuous saturation: counter sticks, then a clear wins over an increment.
    loadCfg(16'd32767, 5'd0);
    applyStimulus('0, '0, 1'b0, '0, '0, 1'b1);
`ifdef ACT_REQUANT_SAT_CNT_EN
    for (int n = 0; n < 65540; n++) begin
      applyStimulus(rep8(8388607), 8'hFF, 1'b0, '0, '0, 1'b0);
    end
    checkVal("sat_sticky", 64'(sat_cnt), 64'(16'hFFFF));
    applyStimulus(rep8(8388607), 8'hFF, 1'b0, '0, '0, 1'b1);
    checkVal("sat_clear_wins", 64'(sat_cnt), 64'(0));
    applyStimulus(rep8(8388607), 8'hFF, 1'b0, '0, '0, 1'b0);
    checkVal("sat_resume", 64'(sat_cnt), 64'(1));
`else
    for (int n = 0; n < 20; n++) begin
      applyStimulus(rep8(8388607), 8'hFF, 1'b0, '0, '0, n == 10);
    end
    checkVal("sat_tied_zero", 64'(sat_cnt), 64'(0));
`endif
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
